// File: rtl/conv_interleaver_ctrl.sv
// Commutator/sequencer for a byte-wide convolutional interleaver: routes each accepted byte
// to one external branch buffer, muxes that branch back out, and tracks sync alignment and fill.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | disabled, no bytes accepted, branch_sel held at 0
// S_SYNC_WT | enabled, discarding bytes until a sync byte arrives
// S_RUN     | aligned, every accepted byte is routed round-robin
module conv_interleaver_ctrl #(
    parameter int NUM_BRANCH = 12,
    parameter int DEPTH_UNIT = 17,
    parameter int DATA_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic                         in_sync,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            buf_data,
    output logic [NUM_BRANCH-1:0]        buf_en,
    input  logic [NUM_BRANCH*DATA_W-1:0] buf_dout,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [3:0]                   branch_sel,
    output logic                         out_filled,
    output logic                         sync_err
);

    localparam int FILL_TH = NUM_BRANCH * (NUM_BRANCH - 1) * DEPTH_UNIT;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC_WT = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            sel_q, sel_d;
    logic [3:0]            osel_q;
    logic [NUM_BRANCH-1:0] buf_en_q;
    logic [DATA_W-1:0]     buf_data_q;
    logic                  sync_err_q;
    logic                  out_valid_q;
    logic [DATA_W-1:0]     out_data_q;
    logic [15:0]           cnt_q;
    logic                  filled_q;

    logic                  accept;
    logic                  route;
    logic [3:0]            route_k;
    logic                  serr;
    logic                  fill_hit;
    logic [DATA_W-1:0]     mux_data;

    assign in_ready = enable && (state_q != S_IDLE);
    assign accept   = in_valid && in_ready;
    assign fill_hit = (32'(cnt_q) + 32'd1) >= 32'(FILL_TH);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        route   = 1'b0;
        route_k = sel_q;
        serr    = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            sel_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_SYNC_WT;
                S_SYNC_WT: begin
                    if (accept && in_sync) begin
                        route   = 1'b1;
                        route_k = '0;
                        sel_d   = 4'd1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        route = 1'b1;
                        // A sync byte off branch 0 forces realignment onto branch 0.
                        if (in_sync && (sel_q != 4'd0)) begin
                            route_k = '0;
                            serr    = 1'b1;
                            sel_d   = 4'd1;
                        end else begin
                            sel_d = (sel_q == 4'(NUM_BRANCH - 1)) ? 4'd0 : sel_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    // Captured on the edge that performs the shift, so this is the branch's pre-shift output.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_BRANCH; k++) begin
            if (osel_q == 4'(k)) mux_data = buf_dout[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            osel_q      <= '0;
            buf_en_q    <= '0;
            buf_data_q  <= '0;
            sync_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            filled_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            buf_en_q    <= route ? (NUM_BRANCH'(1) << route_k) : '0;
            sync_err_q  <= serr;
            out_valid_q <= |buf_en_q;
            if (route) begin
                buf_data_q <= in_data;
                osel_q     <= route_k;
            end
            if (|buf_en_q) out_data_q <= mux_data;
            if (route && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
            if (route && fill_hit) filled_q <= 1'b1;
        end
    end

    assign buf_data   = buf_data_q;
    assign buf_en     = buf_en_q;
    assign sync_err   = sync_err_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign branch_sel = sel_q;
    assign out_filled = filled_q;

endmodule
